video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the HDMI output path, running in the pixel clock domain.
- Produces frame-buffer read addresses, and hsync/vsync/data-enable delayed to match a configurable pixel-fetch latency, so encoder inputs line up with fetched pixel data.
- Adds start/stop control with frame-boundary stop, per-polarity sync, line stride, and frame/line strobes.

Parameters:
- H_PIXEL, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels between active end and hsync start
- H_BACK_PORCH, 48, pixels between hsync end and line end
- H_TOTAL, 800, total pixels per line; must be > H_PIXEL+H_FRONT_PORCH+H_BACK_PORCH
- V_PIXEL, 480, active lines
- V_FRONT_PORCH, 10, lines between active end and vsync start
- V_BACK_PORCH, 33, lines between vsync end and frame end
- V_TOTAL, 525, total lines per frame
- HSYNC_POL, 1, asserted level of hsync
- VSYNC_POL, 1, asserted level of vsync
- ADDR_W, 21, address width
- LINE_STRIDE, 640, address increment per active line; must be >= H_PIXEL
- PIX_LATENCY, 1, pixel-fetch latency in cycles, 0..15

Ports:
- clk_low  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request (level)
- addr  out  ADDR_W  frame-buffer read address
- addr_valid  out  1  addr is an active-area fetch
- de  out  1  data enable, delayed PIX_LATENCY after addr_valid
- hsync  out  1  delayed with de
- vsync  out  1  delayed with de
- frame_start  out  1  one-cycle pulse with addr of pixel (0,0)
- line_start  out  1  one-cycle pulse with addr of pixel x=0 of each active line
- busy  out  1  generator in RUN or STOP_PEND

Behaviour:
- Reset (async): counters h=v=0, state IDLE. All outputs 0, except hsync=!HSYNC_POL and vsync=!VSYNC_POL. The delay line is filled with inactive values.
- States:
  - IDLE: counters held at 0. Goes to RUN when enable=1.
  - RUN: h increments each cycle. At h==H_TOTAL-1, h wraps to 0 and v increments. At the same time, if v==V_TOTAL-1, v wraps to 0. If enable=0 in RUN, go to STOP_PEND.
  - STOP_PEND: continues counting. If enable returns to 1 before the frame ends, go back to RUN. At the last pixel of the frame (h==H_TOTAL-1, v==V_TOTAL-1), go to IDLE with counters at 0.
- A stop never truncates a frame. Re-enable in the same cycle as the frame end keeps RUN with no gap.
- busy = state != IDLE.
- Stage 0 (registered, 1 cycle after counter value), valid only in RUN/STOP_PEND:
  - addr_valid = (h<H_PIXEL) && (v<V_PIXEL).
  - addr = line_base + h, where line_base is 0 at v=0 and increases by LINE_STRIDE after each active line.
  - addr holds its last value when addr_valid=0.
  - Arithmetic is modulo 2^ADDR_W; wrap is silent.
  - hs_raw = H_PIXEL+H_FRONT_PORCH <= h < H_TOTAL-H_BACK_PORCH.
  - vs_raw = V_PIXEL+V_FRONT_PORCH <= v < V_TOTAL-V_BACK_PORCH. vs_raw is evaluated per line and changes only at h==0.
  - frame_start = addr_valid at (0,0); line_start = addr_valid at x=0.
- de/hsync/vsync are stage-0 addr_valid/hs_raw/vs_raw delayed exactly PIX_LATENCY further cycles through a shift register. PIX_LATENCY=0 gives no extra delay. Polarity is applied at the output: hsync = hs_d ? HSYNC_POL : !HSYNC_POL.
- On return to IDLE, the delay line drains naturally; no output glitches.
- reset asserted mid-frame: immediate return to the reset values above. The first frame after reset starts at (0,0).

Decomposition:
- Shared package video_timing_pkg holds:
  - state enum (IDLE, RUN, STOP_PEND)
  - standard timing constant sets (640x480@60, 1280x720@60)
  - a function checking parameter legality
- One natural sub-module, video_delay_line (parametrised width and depth, async reset to a parameter value), used for de/hsync/vsync alignment.
- Counter/FSM and address logic stay in the top.

Test Plan:
Small raster for tests 1–5: H_PIXEL=4, FP=1, BP=1, H_TOTAL=8, V_PIXEL=3, VFP=1, VBP=1, V_TOTAL=6, LINE_STRIDE=6, PIX_LATENCY=2.
1. Basic raster: enable=1 from reset -> addr_valid sequence 4 high/4 low per line on lines 0-2. addr sequence 0,1,2,3 / 6,7,8,9 / 12,13,14,15, then back to 0 at the next frame. Frame period 48 cycles.
2. Sync/latency: same run -> de equals addr_valid delayed 2 cycles. hsync asserted 2 cycles per line, aligned to h=5,6 shifted by 3 cycles from counter. vsync asserted during line v=4 only.
3. Polarity: HSYNC_POL=0, VSYNC_POL=0 -> sync lines idle high and pulse low, with the same timing as test 2. Reset value of hsync/vsync is 1.
4. Graceful stop: drop enable at v=1,h=2 -> counting continues to the frame end, then busy falls and counters reach 0. Raise enable at v=4 instead -> no stop and no gap between frames.
5. Mid-frame reset: assert reset at v=2,h=1 -> all outputs go to reset values immediately. After release with enable=1, the first addr_valid has addr=0 and frame_start pulses.
6. Default 640x480 parameters, PIX_LATENCY=0 -> frame of 420000 cycles. The last active addr is 307199. hsync pulse is 96 cycles wide; vsync pulse is 2 lines wide.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared FSM state type, standard raster timings and a timing legality check
package video_timing_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} vt_state_e;
  typedef struct packed {
    int h_pixel;
    int h_front_porch;
    int h_back_porch;
    int h_total;
    int v_pixel;
    int v_front_porch;
    int v_back_porch;
    int v_total;
  } vt_timing_t;
  localparam vt_timing_t VT_640X480_60 = '{
    h_pixel: 640, h_front_porch: 16, h_back_porch: 48, h_total: 800,
    v_pixel: 480, v_front_porch: 10, v_back_porch: 33, v_total: 525
  };
  localparam vt_timing_t VT_1280X720_60 = '{
    h_pixel: 1280, h_front_porch: 110, h_back_porch: 220, h_total: 1650,
    v_pixel: 720, v_front_porch: 5, v_back_porch: 20, v_total: 750
  };
  function automatic bit timing_ok(input int hp, input int hfp, input int hbp, input int ht,
                                   input int vp, input int vfp, input int vbp, input int vt,
                                   input int stride, input int lat);
    return hp > 0 && vp > 0 && ht > hp + hfp + hbp && vt > vp + vfp + vbp &&
           stride >= hp && lat >= 0 && lat <= 15;
  endfunction
endpackage

// File: rtl/video_delay_line.sv
// video_delay_line: fixed-depth shift register, async reset to an idle value
//   clk_low : clock
//   reset   : async active-high reset, loads RST_VAL into every stage
//   d / q   : W-bit input / output delayed by DEPTH cycles (DEPTH=0 is a wire)
module video_delay_line #(
  parameter int W = 1,
  parameter int DEPTH = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_low,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_low ^ reset;
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [DEPTH];
    always_ff @(posedge clk_low or posedge reset)
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with frame-buffer addressing and latency-matched syncs
//   clk_low/reset         : pixel clock, async active-high reset
//   enable                : run request; dropping it stops at the next frame boundary
//   addr/addr_valid       : frame-buffer fetch address and active-area qualifier
//   de/hsync/vsync        : encoder controls, PIX_LATENCY cycles behind addr_valid
//   frame_start/line_start: strobes coincident with addr of pixel (0,0) / x=0
//   busy                  : generator is counting
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_PIXEL       = VT_640X480_60.h_pixel,
  parameter int H_FRONT_PORCH = VT_640X480_60.h_front_porch,
  parameter int H_BACK_PORCH  = VT_640X480_60.h_back_porch,
  parameter int H_TOTAL       = VT_640X480_60.h_total,
  parameter int V_PIXEL       = VT_640X480_60.v_pixel,
  parameter int V_FRONT_PORCH = VT_640X480_60.v_front_porch,
  parameter int V_BACK_PORCH  = VT_640X480_60.v_back_porch,
  parameter int V_TOTAL       = VT_640X480_60.v_total,
  parameter bit HSYNC_POL     = 1'b1,
  parameter bit VSYNC_POL     = 1'b1,
  parameter int ADDR_W        = 21,
  parameter int LINE_STRIDE   = 640,
  parameter int PIX_LATENCY   = 1
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              line_start,
  output logic              busy
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_PIXEL);
  localparam logic [HW-1:0] HS_BEG = HW'(H_PIXEL + H_FRONT_PORCH);
  localparam logic [HW-1:0] HS_END = HW'(H_TOTAL - H_BACK_PORCH);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_PIXEL);
  localparam logic [VW-1:0] VS_BEG = VW'(V_PIXEL + V_FRONT_PORCH);
  localparam logic [VW-1:0] VS_END = VW'(V_TOTAL - V_BACK_PORCH);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_STRIDE);
  if (!timing_ok(H_PIXEL, H_FRONT_PORCH, H_BACK_PORCH, H_TOTAL, V_PIXEL, V_FRONT_PORCH,
                 V_BACK_PORCH, V_TOTAL, LINE_STRIDE, PIX_LATENCY)) begin : g_bad_timing
    $error("video_timing_gen: illegal timing parameters");
  end
  vt_state_e state, state_nx;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [ADDR_W-1:0] line_base;
  logic active, h_end, frame_end, pix_act, hs_raw, vs_raw, hs_d, vs_d;
  logic [2:0] dly_q;
  assign active    = state != IDLE;
  assign busy      = active;
  assign h_end     = h == H_LAST;
  assign frame_end = h_end && v == V_LAST;
  assign pix_act   = active && h < H_ACT && v < V_ACT;
  // RUN and STOP_PEND differ only in what happens at the frame end; enable always wins,
  // so a re-enable on the last pixel continues with no gap.
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (enable ? RUN : IDLE) :
               enable ? RUN : frame_end ? IDLE : STOP_PEND;
  end
  // Counters only leave zero while active and only go idle at the frame end,
  // so they naturally sit at (0,0) whenever the generator is idle.
  always_ff @(posedge clk_low or posedge reset)
    if (reset) begin
      state     <= IDLE;
      h         <= '0;
      v         <= '0;
      line_base <= '0;
    end else begin
      state <= state_nx;
      if (active) begin
        h <= h_end ? '0 : h + 1'b1;
        if (h_end) begin
          v         <= v == V_LAST ? '0 : v + 1'b1;
          line_base <= v == V_LAST ? '0 : v < V_ACT ? line_base + STRIDE : line_base;
        end
      end
    end
  always_ff @(posedge clk_low or posedge reset)
    if (reset) begin
      addr        <= '0;
      addr_valid  <= 1'b0;
      hs_raw      <= 1'b0;
      vs_raw      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      addr_valid  <= pix_act;
      hs_raw      <= active && h >= HS_BEG && h < HS_END;
      vs_raw      <= active && v >= VS_BEG && v < VS_END;
      frame_start <= pix_act && h == '0 && v == '0;
      line_start  <= pix_act && h == '0;
      if (pix_act) addr <= line_base + ADDR_W'(h);
    end
  video_delay_line #(.W(3), .DEPTH(PIX_LATENCY), .RST_VAL(3'b000)) u_dly (
    .clk_low (clk_low),
    .reset   (reset),
    .d       ({addr_valid, hs_raw, vs_raw}),
    .q       (dly_q)
  );
  assign de    = dly_q[2];
  assign hs_d  = dly_q[1];
  assign vs_d  = dly_q[0];
  assign hsync = hs_d ? HSYNC_POL : !HSYNC_POL;
  assign vsync = vs_d ? VSYNC_POL : !VSYNC_POL;
endmodule
